// File: rtl/riscv_wb_pkg.sv
// Shared constants and load-extension helper for the register-file writeback path.
package riscv_wb_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned NREGS = 32;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Sign/zero-extend right-aligned load data; 111 falls through as a full doubleword
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] funct3,
                                                    input logic [XLEN-1:0] data);
        logic [XLEN-1:0] res;
        res = data;
        case (funct3)
            F3_LB:   res = {{(XLEN-8){data[7]}},   data[7:0]};
            F3_LH:   res = {{(XLEN-16){data[15]}}, data[15:0]};
            F3_LW:   res = {{(XLEN-32){data[31]}}, data[31:0]};
            F3_LBU:  res = {{(XLEN-8){1'b0}},      data[7:0]};
            F3_LHU:  res = {{(XLEN-16){1'b0}},     data[15:0]};
            F3_LWU:  res = {{(XLEN-32){1'b0}},     data[31:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load result buffer: DEPTH entries of {rd, data, dead} with WAW kill and pending mask.
module wb_load_fifo
    import riscv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic [RD_W-1:0] push_rd_i,
    input  logic [DW-1:0]   push_data_i,
    input  logic            pop_i,
    input  logic            kill_i,
    input  logic [RD_W-1:0] kill_rd_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [RD_W-1:0] head_rd_o,
    output logic [DW-1:0]   head_data_o,
    output logic            head_dead_o,
    output logic [NREGS-1:0] pending_mask_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]        wptr_q, wptr_d;
    logic [AW:0]        rptr_q, rptr_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   dead_q, dead_d;
    logic [RD_W-1:0]    rd_q [DEPTH];
    logic [RD_W-1:0]    rd_d [DEPTH];
    logic [DW-1:0]      data_q [DEPTH];
    logic [NREGS-1:0]   mask_q, mask_d;

    logic [AW-1:0]      widx, ridx;
    logic               do_push, do_pop;

    assign widx    = wptr_q[AW-1:0];
    assign ridx    = rptr_q[AW-1:0];
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_rd_o      = rd_q[ridx];
    assign head_data_o    = data_q[ridx];
    assign head_dead_o    = dead_q[ridx];
    assign pending_mask_o = mask_q;

    // Next entry state: kill matching entries, retire head, append tail, rebuild mask
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        dead_d  = dead_q;
        for (int i = 0; i < DEPTH; i++) begin
            rd_d[i] = rd_q[i];
        end
        mask_d  = '0;

        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (rd_q[i] == kill_rd_i)) begin
                    dead_d[i] = 1'b1;
                end
            end
        end
        if (do_pop) begin
            valid_d[ridx] = 1'b0;
            rptr_d        = rptr_q + (AW+1)'(1);
        end
        if (do_push) begin
            valid_d[widx] = 1'b1;
            dead_d[widx]  = 1'b0;
            rd_d[widx]    = push_rd_i;
            wptr_d        = wptr_q + (AW+1)'(1);
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i] && !dead_d[i]) begin
                mask_d[rd_d[i]] = 1'b1;
            end
        end
        mask_d[0] = 1'b0;
    end

    // Pointer, tag and mask registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= '0;
            dead_q  <= '0;
            mask_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            dead_q  <= dead_d;
            mask_q  <= mask_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= rd_d[i];
            end
        end
    end

    // Payload storage; validity is tracked separately so data needs no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[widx] <= push_data_i;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port: arbitrates ALU results over buffered/bypassed load results.
module writeback_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_data,
    output logic            RegWrite,
    output logic [4:0]      RD,
    output logic [XLEN-1:0] WriteData,
    output logic [31:0]     pending_mask
);

    import riscv_wb_pkg::*;

    localparam int unsigned PKG_W = riscv_wb_pkg::XLEN;

    logic               fifo_full, fifo_empty;
    logic [RD_W-1:0]    head_rd;
    logic [XLEN-1:0]    head_data;
    logic               head_dead;
    logic               accept;
    logic [XLEN-1:0]    ext_data;
    logic               push, pop;

    logic               we_q, we_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;

    assign mem_ready = !fifo_full;
    assign accept    = mem_valid && !fifo_full;
    assign ext_data  = XLEN'(load_extend(mem_funct3, PKG_W'(mem_data)));

    wb_load_fifo #(
        .DEPTH (DEPTH),
        .DW    (XLEN)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (push),
        .push_rd_i      (mem_rd),
        .push_data_i    (ext_data),
        .pop_i          (pop),
        .kill_i         (alu_valid),
        .kill_rd_i      (alu_rd),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .head_rd_o      (head_rd),
        .head_data_o    (head_data),
        .head_dead_o    (head_dead),
        .pending_mask_o (pending_mask)
    );

    // Write selection: ALU first, then oldest buffered load, then bypass of a fresh load
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        we_d    = 1'b0;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        if (alu_valid) begin
            we_d    = (alu_rd != '0);
            rd_d    = alu_rd;
            wdata_d = alu_result;
            push    = accept;
        end else if (!fifo_empty) begin
            pop     = 1'b1;
            we_d    = !head_dead && (head_rd != '0);
            rd_d    = head_rd;
            wdata_d = head_data;
            push    = accept;
        end else if (accept) begin
            we_d    = (mem_rd != '0);
            rd_d    = mem_rd;
            wdata_d = ext_data;
        end
    end

    // Registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
        end
    end

    assign RegWrite  = we_q;
    assign RD        = rd_q;
    assign WriteData = wdata_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit against a queue-based reference model.
module tb_writeback_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [63:0] alu_result = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = '0;
    logic [2:0]  mem_funct3 = '0;
    logic [63:0] mem_data = '0;
    logic        RegWrite;
    logic [4:0]  RD;
    logic [63:0] WriteData;
    logic [31:0] pending_mask;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        bit          dead;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] dut_regs [32];

    always #5 clk = ~clk;

    writeback_unit #(.DEPTH(DEPTH), .XLEN(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_result   (alu_result),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_funct3   (mem_funct3),
        .mem_data     (mem_data),
        .RegWrite     (RegWrite),
        .RD           (RD),
        .WriteData    (WriteData),
        .pending_mask (pending_mask)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_ext(input logic [2:0] f3, input logic [63:0] d);
        longint v;
        case (f3)
            3'd0: v = longint'(byte'(d[7:0]));
            3'd1: v = longint'(shortint'(d[15:0]));
            3'd2: v = longint'(int'(d[31:0]));
            3'd4: v = longint'(d & 64'h0000_0000_0000_00FF);
            3'd5: v = longint'(d & 64'h0000_0000_0000_FFFF);
            3'd6: v = longint'(d & 64'h0000_0000_FFFF_FFFF);
            default: v = longint'(d);
        endcase
        return 64'(v);
    endfunction

    function automatic logic [31:0] ref_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) if (!mq[i].dead && mq[i].rd != 0) m = m | (32'd1 << mq[i].rd);
        return m;
    endfunction

    // One input cycle: drive, check pre-edge state, advance model, check write port
    task automatic step(input bit av, input logic [4:0] ard, input logic [63:0] ares,
                        input bit mv, input logic [4:0] mrd, input logic [2:0] f3,
                        input logic [63:0] md);
        bit          acc, exp_we;
        logic [4:0]  exp_rd;
        logic [63:0] exp_data;
        ent_t        e;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_result = ares;
        mem_valid = mv; mem_rd = mrd; mem_funct3 = f3; mem_data = md;
        #1;
        check("mem_ready", 64'(mem_ready), 64'(mq.size() < DEPTH));
        check("pending_mask", 64'(pending_mask), 64'(ref_mask()));
        acc = mv && (mq.size() < DEPTH);
        exp_we = 1'b0; exp_rd = '0; exp_data = '0;
        if (av) begin
            exp_we = (ard != 0); exp_rd = ard; exp_data = ares;
            foreach (mq[i]) if (mq[i].rd == ard) begin e = mq[i]; e.dead = 1; mq[i] = e; end
            if (acc) begin e.rd = mrd; e.data = ref_ext(f3, md); e.dead = 0; mq.push_back(e); end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = !e.dead && (e.rd != 0); exp_rd = e.rd; exp_data = e.data;
            if (acc) begin e.rd = mrd; e.data = ref_ext(f3, md); e.dead = 0; mq.push_back(e); end
        end else if (acc) begin
            exp_we = (mrd != 0); exp_rd = mrd; exp_data = ref_ext(f3, md);
        end
        @(posedge clk);
        #1;
        check("RegWrite", 64'(RegWrite), 64'(exp_we));
        if (exp_we) begin
            check("RD", 64'(RD), 64'(exp_rd));
            check("WriteData", WriteData, exp_data);
        end
        if (RegWrite === 1'b1) dut_regs[RD] = WriteData;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_RegWrite"}, 64'(RegWrite), 64'd0);
        check({tag, "_RD"}, 64'(RD), 64'd0);
        check({tag, "_WriteData"}, WriteData, 64'd0);
        check({tag, "_pending"}, 64'(pending_mask), 64'd0);
        check({tag, "_mem_ready"}, 64'(mem_ready), 64'd1);
    endtask

    initial begin
        foreach (dut_regs[i]) dut_regs[i] = '0;
        #2;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;

        // ALU write latency
        step(1, 5'd5, 64'h1234, 0, 0, 0, 0);
        // Bypassed loads, signed and unsigned byte
        step(0, 0, 0, 1, 5'd7, 3'b000, 64'h80);
        step(0, 0, 0, 1, 5'd7, 3'b100, 64'h80);
        step(0, 0, 0, 1, 5'd8, 3'b010, 64'hDEAD_BEEF_8000_0001);
        idle(1);

        // Fill the buffer behind a busy ALU, then drain in order
        for (int i = 0; i < 5; i++)
            step(1, 5'(10 + i), 64'(100 + i), 1, 5'(20 + i), 3'b011, 64'(64'hA000 + i));
        idle(5);

        // WAW kill of a buffered load
        step(1, 5'd1, 64'd11, 1, 5'd3, 3'b011, 64'h77);
        step(1, 5'd3, 64'd9, 0, 0, 0, 0);
        idle(2);
        check("reg3_final", dut_regs[3], 64'd9);

        // x0 destinations
        step(1, 5'd0, 64'h55, 1, 5'd0, 3'b011, 64'h66);
        step(0, 0, 0, 1, 5'd0, 3'b011, 64'h99);
        idle(2);

        // Reset with loads buffered
        for (int i = 0; i < 3; i++)
            step(1, 5'(1 + i), 64'(i), 1, 5'(4 + i), 3'b011, 64'(i));
        @(negedge clk);
        alu_valid = 0; mem_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        idle(4);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), {$urandom, $urandom});
        end
        idle(DEPTH + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Register-file write-port driver for the 64-bit RISC-V core. Merges single-cycle ALU results and variable-latency load results into the single registered write port (RD, WriteData, RegWrite) consumed by the register file. Load results are sign- or zero-extended per funct3 and buffered in a small FIFO so they never block the ALU. The block also exports a pending-write mask for the hazard unit.

## Interface
- DEPTH, 4: load buffer entries (power of two, ≥2)
- XLEN, 64: data width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle; never back-pressured
- alu_rd  in  5  ALU destination register
- alu_result  in  XLEN  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted when mem_valid && mem_ready
- mem_rd  in  5  load destination register
- mem_funct3  in  3  load type
- mem_data  in  XLEN  raw load data, already right-aligned to bit 0
- RegWrite  out  1  register-file write enable, registered
- RD  out  5  write address, registered
- WriteData  out  XLEN  write data, registered
- pending_mask  out  32  bit r set while a live buffered load targets r; bit 0 always 0

## Operation
- mem_ready = !full; combinational from FIFO state only, never from mem_valid.
- Per-cycle write selection, priority order: (1) alu_valid → write alu_rd/alu_result; (2) else FIFO non-empty → pop head, write it; (3) else accepted load with empty FIFO → bypass, write directly; (4) else RegWrite=0.
- Accepted load not written this cycle is pushed to FIFO tail (extended data stored).
- Push and pop in the same cycle allowed, including when full (pop frees the slot only for the next cycle; mem_ready still 0 while full).
- Extension by mem_funct3: 000 LB sign byte; 001 LH sign half; 010 LW sign word; 011 LD pass; 100 LBU, 101 LHU, 110 LWU zero-extend; 111 treated as LD.
- rd==0: entry accepted/popped normally, RegWrite forced 0 for that write.
- WAW kill: when alu_valid, every FIFO entry with rd==alu_rd is marked dead; a dead entry pops normally with RegWrite=0. A load accepted in the same cycle is younger than the ALU result and is not killed.
- pending_mask: OR over live (not dead) entries of one-hot(rd); excludes the bypass path and entries killed this cycle take effect next cycle.

## Timing
- Reset values: RegWrite=0, RD=0, WriteData=0, FIFO empty, pending_mask=0, mem_ready=1.
- Reset mid-operation discards all buffered loads; no write issued after reset deassertion until new input.
- Latency: ALU result and bypassed load appear on the write port exactly 1 cycle after the input cycle.
- Buffered load written in the first cycle after acceptance with no alu_valid and no older entry.
- Throughput: one register write per cycle; FIFO drains at one entry per ALU-idle cycle.
- Pointer wrap: log2(DEPTH)+1-bit read/write pointers; full when MSBs differ and low bits equal.

## Structure
- Package riscv_wb_pkg: XLEN, load funct3 constants (LB..LWU), load-extension function.
- Sub-module wb_load_fifo: DEPTH-entry FIFO of {rd, data, dead}, with kill-by-rd input and pending-mask output.
- Top handles arbitration, extension, output register.

## Test plan
- Reset then alu_valid, alu_rd=5, alu_result=0x1234 → next cycle RegWrite=1, RD=5, WriteData=0x1234.
- Load funct3=000, mem_data=0x80, rd=7, no ALU → next cycle WriteData=0xFFFF_FFFF_FFFF_FF80; funct3=100 same data → 0x80.
- Continuous alu_valid while 5 loads offered (DEPTH=4) → 4 accepted, mem_ready=0 on 5th, pending_mask shows rds; ALU stops → loads written in order on 4 consecutive cycles.
- Load rd=3 buffered, then alu_valid rd=3 value 9 → ALU write issued, pending_mask[3] clears, later pop yields RegWrite=0; register 3 final value 9.
- Load or ALU with rd=0 → RegWrite stays 0, FIFO occupancy returns to 0.
- Reset asserted with 3 entries buffered → outputs to reset values immediately, no writes after release, mem_ready=1.
